// File: rtl/full_subtractor_struct.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor_struct
// Purpose  : Registered ripple-borrow subtractor (A - B - BIN) built from
//            gate-level 1-bit cells. Optional OVF port via FULL_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor_struct #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BIN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef FULL_SUB_OVF_EN
    output logic             OVF,
`endif
    output logic             BOUT,
    output logic [WIDTH-1:0] SUB
);

    // w_borrow[i] is the borrow into cell i; w_borrow[WIDTH] leaves the MSB.
    logic [WIDTH:0]   w_borrow;
    logic [WIDTH-1:0] w_diff;

    assign w_borrow[0] = BIN;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign w_diff[gi]     = A[gi] ^ B[gi] ^ w_borrow[gi];
            assign w_borrow[gi+1] = (~A[gi] & B[gi])
                                  | (~(A[gi] ^ B[gi]) & w_borrow[gi]);
        end
    endgenerate

    logic [WIDTH-1:0] w_sub_d;
    logic             w_bout_d;
    logic [WIDTH-1:0] r_sub_q;
    logic             r_bout_q;

    always_comb begin
        w_sub_d  = w_diff;
        w_bout_d = w_borrow[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub_q  <= '0;
            r_bout_q <= 1'b0;
        end else begin
            r_sub_q  <= w_sub_d;
            r_bout_q <= w_bout_d;
        end
    end

    assign SUB  = r_sub_q;
    assign BOUT = r_bout_q;

`ifdef FULL_SUB_OVF_EN
    // Signed overflow: borrow into the MSB cell differs from borrow out of it.
    logic w_ovf_d;
    logic r_ovf_q;

    always_comb begin
        w_ovf_d = w_borrow[WIDTH] ^ w_borrow[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_q <= 1'b0;
        end else begin
            r_ovf_q <= w_ovf_d;
        end
    end

    assign OVF = r_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_subtractor_struct.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_subtractor_struct
// Purpose  : Self-checking bench for WIDTH=1 and WIDTH=8 subtractor instances
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_full_subtractor_struct;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bin1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic       bout1;
    logic [0:0] sub1;
    logic       bin8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       bout8;
    logic [7:0] sub8;
`ifdef FULL_SUB_OVF_EN
    logic       ovf1, ovf8;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    full_subtractor_struct #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .BIN (bin1),
        .A   (a1),
        .B   (b1),
`ifdef FULL_SUB_OVF_EN
        .OVF (ovf1),
`endif
        .BOUT(bout1),
        .SUB (sub1)
    );

    full_subtractor_struct #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .BIN (bin8),
        .A   (a8),
        .B   (b8),
`ifdef FULL_SUB_OVF_EN
        .OVF (ovf8),
`endif
        .BOUT(bout8),
        .SUB (sub8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one vector pair, clock once, and compare against the model.
    task automatic step(input logic r,
                        input logic va1, input logic vb1, input logic vc1,
                        input logic [7:0] va8, input logic [7:0] vb8, input logic vc8);
        int  d1, d8, s8;
        logic       e_sub1, e_bout1, e_bout8, e_ovf8;
        logic [7:0] e_sub8;
        rst = r; a1 = va1; b1 = vb1; bin1 = vc1;
        a8 = va8; b8 = vb8; bin8 = vc8;
        d1      = int'(va1) - int'(vb1) - int'(vc1);
        e_sub1  = (d1 & 1) != 0;
        e_bout1 = d1 < 0;
        d8      = int'(va8) - int'(vb8) - int'(vc8);
        e_sub8  = 8'((d8 + 256) % 256);
        e_bout8 = int'(va8) < int'(vb8) + int'(vc8);
        s8      = int'($signed(va8)) - int'($signed(vb8)) - int'(vc8);
        e_ovf8  = (s8 > 127) || (s8 < -128);
        if (r) begin
            e_sub1 = 1'b0; e_bout1 = 1'b0; e_sub8 = 8'h00; e_bout8 = 1'b0; e_ovf8 = 1'b0;
        end
        @(posedge clk);
        #1;
        check("sub1",  64'(sub1),  64'(e_sub1));
        check("bout1", 64'(bout1), 64'(e_bout1));
        check("sub8",  64'(sub8),  64'(e_sub8));
        check("bout8", 64'(bout8), 64'(e_bout8));
`ifdef FULL_SUB_OVF_EN
        check("ovf8",  64'(ovf8),  64'(e_ovf8));
`else
        if (e_ovf8) begin end
`endif
    endtask

    initial begin
        logic [2:0] tt;
        // Reset held over two edges with non-zero inputs, then released.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1);

        // Full WIDTH=1 truth table, back to back, with the 8-bit boundary cases alongside.
        for (int i = 0; i < 8; i++) begin
            tt = 3'(i);
            case (i)
                0: step(1'b0, tt[2], tt[1], tt[0], 8'h00, 8'hFF, 1'b1);
                1: step(1'b0, tt[2], tt[1], tt[0], 8'h5A, 8'h5A, 1'b1);
                2: step(1'b0, tt[2], tt[1], tt[0], 8'h5A, 8'h5A, 1'b0);
                3: step(1'b0, tt[2], tt[1], tt[0], 8'h80, 8'h01, 1'b0);
                4: step(1'b0, tt[2], tt[1], tt[0], 8'h05, 8'h03, 1'b0);
                5: step(1'b0, tt[2], tt[1], tt[0], 8'h7F, 8'hFF, 1'b0);
                6: step(1'b0, tt[2], tt[1], tt[0], 8'hFF, 8'h00, 1'b1);
                default: step(1'b0, tt[2], tt[1], tt[0], 8'h00, 8'h00, 1'b1);
            endcase
        end

        // Mid-stream reset for one edge, then streaming resumes.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h20, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 8'h11, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h44, 1'b1);

        // Random streaming with occasional reset edges.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
